uart_word_assembler: RTL and testbench
======================================

Name: uart_word_assembler

Overview:
- Parametrised successor to the UART receive buffer.
- Packs BYTES consecutive UART receive bytes into one word with selectable byte order.
- Presents each word on a valid/ready output handshake.
- Flags a stalled partial word (inter-byte timeout) and words lost to back-pressure (overrun).
- Sits between the UART receiver and the game-state/packet decoding logic.

Parameters:
- BYTES, 4: bytes per word; legal range 2..8; word width is 8*BYTES.
- MSB_FIRST, 0: 0 = first received byte lands in [7:0] (little-endian); 1 = first byte lands in the top byte.
- TIMEOUT_CYCLES, 100000: clk cycles allowed between bytes of one word before the partial word is dropped; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
- rx_data  input  8  received byte
- word_data  output  8*BYTES  assembled word, registered
- word_valid  output  1  word_data holds an unconsumed word
- word_ready  input  1  consumer accepts word_data this cycle
- byte_cnt  output  $clog2(BYTES+1)  bytes collected in the current partial word
- overrun  output  1  one-cycle pulse: completed word dropped
- timeout  output  1  one-cycle pulse: partial word discarded

Behaviour:
- Reset (asynchronous, active-high): all outputs, the assembly register, the timeout counter and the FSM clear immediately. word_data=0, word_valid=0, byte_cnt=0, overrun=0, timeout=0, FSM=IDLE.
- Reset mid-word drops the partial word with no pulse.

Assembly FSM (independent of the output register):
- IDLE: byte_cnt=0. On rx_valid, store the byte at slot 0, set byte_cnt=1, go to COLLECT.
- COLLECT: each rx_valid stores rx_data at slot byte_cnt and increments byte_cnt.
- Slot k maps to bits [8k+7:8k] when MSB_FIRST=0, and to [8(BYTES-1-k)+7 : 8(BYTES-1-k)] when MSB_FIRST=1.
- On the rx_valid that fills slot BYTES-1, the word is complete. On that clock edge, byte_cnt returns to 0 and the FSM returns to IDLE.

Word hand-off (on completion):
- Output free (word_valid=0), or word_ready=1 in the same cycle: on the completion edge, word_data loads the full word (including the final byte) and word_valid=1.
- Latency: word_valid rises one cycle after the last rx_valid.
- Output occupied and word_ready=0: the new word is discarded. word_data is unchanged and overrun pulses high for one cycle.
- Assembly bytes not used in the new word are cleared to 0 after every hand-off or drop.

Output handshake:
- The transfer completes on any cycle where word_valid and word_ready are both high.
- word_valid falls on the next edge unless a new word loads on that same edge, in which case it stays high.
- word_data is stable while word_valid=1 and word_ready=0.
- word_ready is ignored while word_valid=0.

Timeout:
- The counter clears on every rx_valid and on entry to IDLE. It increments each cycle in COLLECT.
- When it reaches TIMEOUT_CYCLES with no rx_valid: discard the partial word, set byte_cnt=0, go to IDLE, pulse timeout for one cycle.
- If rx_valid arrives in the same cycle the counter reaches the limit, the byte wins: no timeout, the byte is stored and the counter clears.
- TIMEOUT_CYCLES=0: the counter is held at 0 and never fires.

Continuity:
- Back-to-back rx_valid on consecutive cycles is supported with no lost bytes.
- A new word may begin assembling in the cycle immediately after completion.

Test Plan:
- BYTES=4, MSB_FIRST=0; bytes 0x11,0x22,0x33,0x44, word_ready=1 -> word_data=0x44332211, word_valid high for exactly 1 cycle, one cycle after the 4th strobe.
- MSB_FIRST=1; same bytes -> word_data=0x11223344. BYTES=2 with bytes 0xAB,0xCD -> 0xABCD.
- word_ready=0; send 8 bytes 0x01..0x08 -> first word 0x04030201 is held, overrun pulses once after byte 8. Raise word_ready -> 0x04030201 is consumed and no second word appears.
- TIMEOUT_CYCLES=20; send 0xAA,0xBB, idle 20 cycles -> timeout pulse, byte_cnt=0. Then send 0x01,0x02,0x03,0x04 -> word 0x04030201, no stale bytes.
- Send 4 bytes on consecutive cycles while a previous word is consumed on the completion cycle -> both words delivered, word_valid stays high continuously, no overrun.
- Assert rst after 2 bytes -> all outputs 0 immediately (asynchronous). After release, 4 fresh bytes produce a correct word.

Source files
------------

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle for uart_word_assembler.
// slave is the assembler side; master is the UART/consumer side.
interface uart_word_assembler_if #(
  parameter int BYTES = 4
);
  localparam int CW = $clog2(BYTES + 1);

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [8*BYTES-1:0]   word_data;
  logic                 word_valid;
  logic                 word_ready;
  logic [CW-1:0]        byte_cnt;
  logic                 overrun;
  logic                 timeout;

  modport slave (
    input  rx_valid, rx_data, word_ready,
    output word_data, word_valid, byte_cnt, overrun, timeout
  );

  modport master (
    output rx_valid, rx_data, word_ready,
    input  word_data, word_valid, byte_cnt, overrun, timeout
  );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs BYTES UART bytes into one word and offers it on a valid/ready port,
// with an inter-byte timeout for stalled partial words and an overrun flag.
module uart_word_assembler #(
  parameter int BYTES          = 4,
  parameter bit MSB_FIRST      = 1'b0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_word_assembler_if.slave  bus
);
  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(BYTES - 1);
  localparam logic [TW-1:0] TLIM1 = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_asm, w_asm_nxt, w_asm_ins;
  logic [W-1:0]  r_word;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_valid, r_ovr, r_to;
  logic          w_done, w_to, w_load;

  // Assembly register with the incoming byte dropped into slot r_cnt.
  always_comb begin
    w_asm_ins = r_asm;
    for (int k = 0; k < BYTES; k++) begin
      if (r_cnt == CW'(k))
        w_asm_ins[(MSB_FIRST ? (BYTES - 1 - k) : k) * 8 +: 8] = bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_tmo_nxt   = r_tmo;
    w_done      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmo_nxt = '0;
        if (bus.rx_valid) begin
          w_asm_nxt   = w_asm_ins;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.rx_valid) begin
          w_tmo_nxt = '0;
          if (r_cnt == LAST) begin
            w_done      = 1'b1;
            w_asm_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_asm_nxt = w_asm_ins;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          // The limit is hit on this edge; a byte in the same cycle takes priority above.
          if (r_tmo == TLIM1) begin
            w_to        = 1'b1;
            w_asm_nxt   = '0;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load = w_done && (!r_valid || bus.word_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm   <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_asm <= w_asm_nxt;
      r_cnt <= w_cnt_nxt;
      r_tmo <= w_tmo_nxt;
      r_ovr <= w_done && !w_load;
      r_to  <= w_to;
      if (w_load) begin
        r_word  <= w_asm_ins;
        r_valid <= 1'b1;
      end else if (r_valid && bus.word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.word_data  = r_word;
  assign bus.word_valid = r_valid;
  assign bus.byte_cnt   = r_cnt;
  assign bus.overrun    = r_ovr;
  assign bus.timeout    = r_to;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench: LSB-first (timeout 20), MSB-first (no timeout) and 2-byte MSB-first instances.
module tb_uart_word_assembler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tmo_at;
  int   tmo_n;

  always #5 clk = ~clk;

  uart_word_assembler_if #(.BYTES(4)) ia ();
  uart_word_assembler_if #(.BYTES(4)) ib ();
  uart_word_assembler_if #(.BYTES(2)) ic ();

  uart_word_assembler #(.BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(20)) u_lsb (
    .clk(clk), .rst(rst), .bus(ia));
  uart_word_assembler #(.BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .bus(ib));
  uart_word_assembler #(.BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(20)) u_b2 (
    .clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte strobe into both 4-byte instances; returns at the following negedge.
  task automatic put(input logic [7:0] d);
    ia.rx_valid = 1'b1; ia.rx_data = d;
    ib.rx_valid = 1'b1; ib.rx_data = d;
    @(negedge clk);
    ia.rx_valid = 1'b0;
    ib.rx_valid = 1'b0;
  endtask

  task automatic rdy(input logic r);
    ia.word_ready = r;
    ib.word_ready = r;
  endtask

  initial begin
    ia.rx_valid = 1'b0; ia.rx_data = '0; ia.word_ready = 1'b0;
    ib.rx_valid = 1'b0; ib.rx_data = '0; ib.word_ready = 1'b0;
    ic.rx_valid = 1'b0; ic.rx_data = '0; ic.word_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_data",  ia.word_data,  0);
    chk("rst_valid", ia.word_valid, 0);
    chk("rst_cnt",   ia.byte_cnt,   0);
    chk("rst_ovr",   ia.overrun,    0);
    chk("rst_tmo",   ia.timeout,    0);
    @(negedge clk);
    rst = 1'b0;

    // Basic LSB-first / MSB-first assembly, one-cycle valid
    rdy(1'b1);
    put(8'h11); put(8'h22); put(8'h33);
    chk("b3_cnt",   ia.byte_cnt,   3);
    chk("b3_valid", ia.word_valid, 0);
    put(8'h44);
    chk("lsb_word",  ia.word_data,  64'h44332211);
    chk("lsb_valid", ia.word_valid, 1);
    chk("lsb_cnt",   ia.byte_cnt,   0);
    chk("msb_word",  ib.word_data,  64'h11223344);
    @(negedge clk);
    chk("lsb_valid_drop", ia.word_valid, 0);

    // Two-byte MSB-first
    ic.word_ready = 1'b1;
    ic.rx_valid = 1'b1; ic.rx_data = 8'hAB;
    @(negedge clk);
    ic.rx_data = 8'hCD;
    @(negedge clk);
    ic.rx_valid = 1'b0;
    chk("b2_word",  ic.word_data,  64'hABCD);
    chk("b2_valid", ic.word_valid, 1);

    // Back-pressure overrun
    rdy(1'b0);
    for (int i = 1; i <= 8; i++) begin
      put(8'(i));
      if (i == 4) begin
        chk("ovr_first", ia.word_data, 64'h04030201);
        chk("ovr_none4", ia.overrun,   0);
      end
    end
    chk("ovr_pulse", ia.overrun,    1);
    chk("ovr_hold",  ia.word_data,  64'h04030201);
    @(negedge clk);
    chk("ovr_once",  ia.overrun,    0);
    chk("ovr_held",  ia.word_valid, 1);
    rdy(1'b1);
    @(negedge clk);
    chk("ovr_take",  ia.word_valid, 0);
    @(negedge clk);
    chk("ovr_nonew", ia.word_valid, 0);

    // Byte arriving on the limit cycle wins; then a real timeout
    put(8'hAA);
    tmo_n = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (ia.timeout) tmo_n++;
    end
    put(8'hBB);
    chk("tmo_bytewins_n", tmo_n,       0);
    chk("tmo_bytewins",   ia.timeout,  0);
    chk("tmo_cnt2",       ia.byte_cnt, 2);
    tmo_at = 0; tmo_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ia.timeout) begin
        tmo_n++;
        if (tmo_at == 0) tmo_at = i;
      end
    end
    chk("tmo_at",    tmo_at,      20);
    chk("tmo_once",  tmo_n,       1);
    chk("tmo_cnt0",  ia.byte_cnt, 0);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    chk("tmo_fresh", ia.word_data, 64'h04030201);
    @(negedge clk);

    // Back-to-back words with consume on the completion cycle
    rdy(1'b0);
    put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
    chk("b2b_w1", ia.word_data, 64'hA4A3A2A1);
    put(8'hB1); chk("b2b_v1", ia.word_valid, 1);
    put(8'hB2); chk("b2b_v2", ia.word_valid, 1);
    put(8'hB3); chk("b2b_v3", ia.word_valid, 1);
    rdy(1'b1);
    put(8'hB4);
    chk("b2b_w2",    ia.word_data,  64'hB4B3B2B1);
    chk("b2b_v4",    ia.word_valid, 1);
    chk("b2b_noovr", ia.overrun,    0);
    @(negedge clk);
    chk("b2b_drain", ia.word_valid, 0);

    // Asynchronous reset mid-word with a word held
    rdy(1'b0);
    put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
    put(8'h55); put(8'h66);
    chk("pre_rst_cnt",  ia.byte_cnt,  2);
    chk("pre_rst_data", ia.word_data, 64'hC4C3C2C1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  ia.word_data,  0);
    chk("arst_valid", ia.word_valid, 0);
    chk("arst_cnt",   ia.byte_cnt,   0);
    @(negedge clk);
    rst = 1'b0;
    rdy(1'b1);
    put(8'h05); put(8'h06); put(8'h07); put(8'h08);
    chk("post_rst_word",  ia.word_data,  64'h08070605);
    chk("post_rst_valid", ia.word_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
